// File: rtl/ibex_bcp_region_alloc_pkg.sv
// Shared types and constants for the bound-checking region allocator.
// Tag layout matches the checker: tag[7:6]==2'b11 marks a region pointer.
package ibex_bcp_region_alloc_pkg;

   localparam int unsigned BCP_XLEN  = 32;
   localparam int unsigned BCP_TAG_W = 8;
   localparam int unsigned BCP_ALEN  = BCP_XLEN - BCP_TAG_W;

   localparam logic [1:0]  BCP_TAG_REGION    = 2'b11;
   localparam logic [23:0] BCP_TAG_INV_START = 24'hFFFFFF;

   typedef enum logic {
      BCP_OP_ALLOC = 1'b0,
      BCP_OP_FREE  = 1'b1
   } bcp_alloc_op_e;

   typedef enum logic [1:0] {
      BCP_ERR_OK      = 2'd0,
      BCP_ERR_BADSIZE = 2'd1,
      BCP_ERR_NOFREE  = 2'd2,
      BCP_ERR_BADFREE = 2'd3
   } bcp_alloc_err_e;

   typedef enum logic [1:0] {
      BCP_ST_IDLE     = 2'd0,
      BCP_ST_WR_START = 2'd1,
      BCP_ST_WR_END   = 2'd2,
      BCP_ST_RESP     = 2'd3
   } bcp_alloc_state_e;

   // Bit0 stays clear so the tag can never collide with the all-ones tag.
   function automatic logic [7:0] bcp_pair_tag(input logic [4:0] pair);
      return {BCP_TAG_REGION, pair, 1'b0};
   endfunction

endpackage

// File: rtl/ibex_bcp_region_alloc_free_finder.sv
// Lowest-set-bit priority encoder with an any-set flag, used to pick the
// next free region pair.
module ibex_bcp_free_finder #(
   parameter int unsigned N = 2,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] free_vec,
   output logic [W-1:0] sel_idx,
   output logic         any_free
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      sel_idx = {W{1'b0}};
      for (int i = int'(N) - 1; i >= 0; i--) begin
         sel_idx = free_vec[i] ? W'(i) : sel_idx;
      end
   end

   assign any_free = |free_vec;

endmodule

// File: rtl/ibex_bcp_region_alloc.sv
// Region allocator: programs start/end CSR entry pairs and hands out tagged
// pointers; FREE rewrites a pair as start>end so stale pointers fault.
module ibex_bcp_region_alloc
   import ibex_bcp_region_alloc_pkg::*;
#(
   parameter int unsigned BCPNumRegions = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic                               req_op_i,
   input  logic [23:0]                        req_base_i,
   input  logic [23:0]                        req_size_i,
   input  logic [31:0]                        req_ptr_i,
   output logic                               resp_valid_o,
   input  logic                               resp_ready_i,
   output logic [31:0]                        resp_ptr_o,
   output logic [1:0]                         resp_err_o,
   output logic                               csr_we_o,
   output logic [$clog2(BCPNumRegions)-1:0]   csr_widx_o,
   output logic [31:0]                        csr_wdata_o
);

   localparam int unsigned NumPairs = BCPNumRegions / 2;
   localparam int unsigned PairW    = (NumPairs > 1) ? $clog2(NumPairs) : 1;
   localparam int unsigned IdxW     = $clog2(BCPNumRegions);

   bcp_alloc_state_e    state_r, state_next_s;
   bcp_alloc_op_e       op_r;
   bcp_alloc_err_e      req_err_s, resp_err_r, resp_err_next_s;
   logic [NumPairs-1:0] bitmap_r;
   logic [PairW-1:0]    find_idx_s, free_pair_s, req_pair_s, pair_r;
   logic                find_any_s, accept_s, size_bad_s, free_bad_s;
   logic [24:0]         end_sum_s;
   logic [4:0]          free_k_s;
   logic [7:0]          req_tag_s, tag_r;
   logic [23:0]         req_start_s, req_end_s, start_r, end_r;
   logic                req_ready_r, csr_we_r, csr_we_next_s;
   logic [IdxW-1:0]     csr_widx_r, csr_widx_next_s;
   logic [31:0]         csr_wdata_r, csr_wdata_next_s;
   logic                resp_valid_r, resp_valid_next_s;
   logic [31:0]         resp_ptr_r, resp_ptr_next_s;
   logic                unused_ptr_s;

   ibex_bcp_free_finder #(
      .N (NumPairs),
      .W (PairW)
   ) u_free_finder (
      .free_vec (bitmap_r),
      .sel_idx  (find_idx_s),
      .any_free (find_any_s)
   );

   // The pair index lives in tag[5:1]; the address part of a FREE pointer is irrelevant.
   assign free_k_s     = req_ptr_i[29:25];
   assign free_pair_s  = PairW'(free_k_s);
   assign unused_ptr_s = ^req_ptr_i[24:0];
   assign end_sum_s    = {1'b0, req_base_i} + {1'b0, req_size_i} - 25'd1;
   assign size_bad_s   = (req_size_i == 24'd0) || end_sum_s[24];
   assign free_bad_s   = (req_ptr_i[31:30] != BCP_TAG_REGION)
                         || ({27'd0, free_k_s} >= NumPairs)
                         || bitmap_r[free_pair_s];

   assign accept_s    = (state_r == BCP_ST_IDLE) && req_valid_i;
   assign req_pair_s  = (req_op_i == BCP_OP_FREE) ? free_pair_s : find_idx_s;
   assign req_tag_s   = bcp_pair_tag(5'(req_pair_s));
   assign req_start_s = (req_op_i == BCP_OP_FREE) ? BCP_TAG_INV_START : req_base_i;
   assign req_end_s   = (req_op_i == BCP_OP_FREE) ? 24'h000000 : end_sum_s[23:0];

   // Request error classification in priority order.
   always_comb begin
      req_err_s = BCP_ERR_OK;
      if (req_op_i == BCP_OP_FREE) begin
         req_err_s = free_bad_s ? BCP_ERR_BADFREE : BCP_ERR_OK;
      end else if (size_bad_s) begin
         req_err_s = BCP_ERR_BADSIZE;
      end else if (!find_any_s) begin
         req_err_s = BCP_ERR_NOFREE;
      end else begin
         req_err_s = BCP_ERR_OK;
      end
   end

   // Next-state and next-output logic; outputs are registered from these.
   always_comb begin
      state_next_s      = state_r;
      csr_we_next_s     = 1'b0;
      csr_widx_next_s   = {IdxW{1'b0}};
      csr_wdata_next_s  = 32'h0000_0000;
      resp_valid_next_s = resp_valid_r;
      resp_ptr_next_s   = resp_ptr_r;
      resp_err_next_s   = resp_err_r;
      case (state_r)
         BCP_ST_IDLE: begin
            if (accept_s && (req_err_s != BCP_ERR_OK)) begin
               state_next_s      = BCP_ST_RESP;
               resp_valid_next_s = 1'b1;
               resp_ptr_next_s   = 32'h0000_0000;
               resp_err_next_s   = req_err_s;
            end else if (accept_s) begin
               state_next_s     = BCP_ST_WR_START;
               csr_we_next_s    = 1'b1;
               csr_widx_next_s  = IdxW'({req_pair_s, 1'b0});
               csr_wdata_next_s = {req_tag_s, req_start_s};
            end else begin
               state_next_s = BCP_ST_IDLE;
            end
         end
         BCP_ST_WR_START: begin
            state_next_s     = BCP_ST_WR_END;
            csr_we_next_s    = 1'b1;
            csr_widx_next_s  = IdxW'({pair_r, 1'b1});
            csr_wdata_next_s = {tag_r, end_r};
         end
         BCP_ST_WR_END: begin
            state_next_s      = BCP_ST_RESP;
            resp_valid_next_s = 1'b1;
            resp_ptr_next_s   = (op_r == BCP_OP_ALLOC) ? {tag_r, start_r} : 32'h0000_0000;
            resp_err_next_s   = BCP_ERR_OK;
         end
         BCP_ST_RESP: begin
            if (resp_ready_i) begin
               state_next_s      = BCP_ST_IDLE;
               resp_valid_next_s = 1'b0;
               resp_ptr_next_s   = 32'h0000_0000;
               resp_err_next_s   = BCP_ERR_OK;
            end else begin
               state_next_s = BCP_ST_RESP;
            end
         end
         default: begin
            state_next_s      = BCP_ST_IDLE;
            resp_valid_next_s = 1'b0;
            resp_ptr_next_s   = 32'h0000_0000;
            resp_err_next_s   = BCP_ERR_OK;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= BCP_ST_IDLE;
         req_ready_r  <= 1'b1;
         csr_we_r     <= 1'b0;
         csr_widx_r   <= {IdxW{1'b0}};
         csr_wdata_r  <= 32'h0000_0000;
         resp_valid_r <= 1'b0;
         resp_ptr_r   <= 32'h0000_0000;
         resp_err_r   <= BCP_ERR_OK;
      end else begin
         state_r      <= state_next_s;
         req_ready_r  <= (state_next_s == BCP_ST_IDLE);
         csr_we_r     <= csr_we_next_s;
         csr_widx_r   <= csr_widx_next_s;
         csr_wdata_r  <= csr_wdata_next_s;
         resp_valid_r <= resp_valid_next_s;
         resp_ptr_r   <= resp_ptr_next_s;
         resp_err_r   <= resp_err_next_s;
      end
   end

   // Request capture on accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_r    <= BCP_OP_ALLOC;
         pair_r  <= {PairW{1'b0}};
         tag_r   <= 8'h00;
         start_r <= 24'h000000;
         end_r   <= 24'h000000;
      end else if (accept_s) begin
         op_r    <= bcp_alloc_op_e'(req_op_i);
         pair_r  <= req_pair_s;
         tag_r   <= req_tag_s;
         start_r <= req_start_s;
         end_r   <= req_end_s;
      end
   end

   // Free bitmap: updated once both entries of the pair are written.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bitmap_r <= {NumPairs{1'b1}};
      end else if (state_r == BCP_ST_WR_END) begin
         bitmap_r[pair_r] <= (op_r == BCP_OP_FREE);
      end
   end

   assign req_ready_o  = req_ready_r;
   assign csr_we_o     = csr_we_r;
   assign csr_widx_o   = csr_widx_r;
   assign csr_wdata_o  = csr_wdata_r;
   assign resp_valid_o = resp_valid_r;
   assign resp_ptr_o   = resp_ptr_r;
   assign resp_err_o   = resp_err_r;

endmodule

// File: tb/tb_ibex_bcp_region_alloc.sv
// Scoreboard bench for ibex_bcp_region_alloc: expected CSR writes and
// responses are queued at request time and compared as the DUT emits them.
module tb_ibex_bcp_region_alloc;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_op_i = 1'b0;
   logic [23:0] req_base_i = 24'h0;
   logic [23:0] req_size_i = 24'h0;
   logic [31:0] req_ptr_i = 32'h0;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b1;
   logic [31:0] resp_ptr_o;
   logic [1:0]  resp_err_o;
   logic        csr_we_o;
   logic [1:0]  csr_widx_o;
   logic [31:0] csr_wdata_o;

   ibex_bcp_region_alloc #(.BCPNumRegions(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_base_i   (req_base_i),
      .req_size_i   (req_size_i),
      .req_ptr_i    (req_ptr_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_ptr_o   (resp_ptr_o),
      .resp_err_o   (resp_err_o),
      .csr_we_o     (csr_we_o),
      .csr_widx_o   (csr_widx_o),
      .csr_wdata_o  (csr_wdata_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {int cyc; logic [1:0] idx; logic [31:0] data;} csr_exp_t;
   typedef struct {int cyc; logic [31:0] ptr; logic [1:0] err;} resp_exp_t;

   csr_exp_t  csr_q[$];
   resp_exp_t resp_q[$];
   int        vectors = 0;
   int        miscompares = 0;
   int        cyc = 0;
   bit        mon_en = 1'b0;
   logic      prev_rv = 1'b0;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_FREE  = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk_i) begin
      if (mon_en) begin
         if (csr_we_o) begin
            if (csr_q.size() != 0) begin
               csr_exp_t e;
               e = csr_q.pop_front();
               check_eq("csr_cycle", cyc, e.cyc);
               check_eq("csr_widx", 32'(csr_widx_o), 32'(e.idx));
               check_eq("csr_wdata", csr_wdata_o, e.data);
            end else begin
               check_eq("csr_spurious_we", 32'(csr_we_o), 32'd0);
            end
         end else begin
            check_eq("csr_idle_widx", 32'(csr_widx_o), 32'd0);
            check_eq("csr_idle_wdata", csr_wdata_o, 32'd0);
         end
         if (resp_valid_o) begin
            if (resp_q.size() == 0) begin
               check_eq("resp_spurious_valid", 32'(resp_valid_o), 32'd0);
            end else begin
               if (!prev_rv) check_eq("resp_rise_cycle", cyc, resp_q[0].cyc);
               if (resp_ready_i) begin
                  resp_exp_t r;
                  r = resp_q.pop_front();
                  check_eq("resp_ptr", resp_ptr_o, r.ptr);
                  check_eq("resp_err", 32'(resp_err_o), 32'(r.err));
               end
            end
         end
         prev_rv <= resp_valid_o;
      end else begin
         prev_rv <= 1'b0;
      end
   end

   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!req_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      ok = req_ready_o;
      if (!ok) check_eq("req_ready_timeout", 32'(req_ready_o), 32'd1);
   endtask

   // Drive one request and queue its expected writes and response.
   task automatic issue(input logic op, input logic [23:0] base, input logic [23:0] size,
                        input logic [31:0] ptr, input logic [1:0] eerr, input logic [31:0] eptr,
                        input logic [1:0] eidx, input logic [31:0] d0, input logic [31:0] d1);
      bit ok;
      int c;
      wait_ready(ok);
      if (ok) begin
         req_op_i    = op;
         req_base_i  = base;
         req_size_i  = size;
         req_ptr_i   = ptr;
         req_valid_i = 1'b1;
         c = cyc + 1;
         if (eerr == 2'd0) begin
            csr_q.push_back('{c, eidx, d0});
            csr_q.push_back('{c + 1, eidx + 2'd1, d1});
            resp_q.push_back('{c + 2, eptr, eerr});
         end else begin
            resp_q.push_back('{c, eptr, eerr});
         end
         @(posedge clk_i);
         #1 req_valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((csr_q.size() != 0 || resp_q.size() != 0) && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (csr_q.size() != 0 || resp_q.size() != 0)
         check_eq("drain_timeout", csr_q.size() + resp_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_req_ready"}, 32'(req_ready_o), 32'd1);
      check_eq({pfx, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
      check_eq({pfx, "_resp_ptr"}, resp_ptr_o, 32'd0);
      check_eq({pfx, "_resp_err"}, 32'(resp_err_o), 32'd0);
      check_eq({pfx, "_csr_we"}, 32'(csr_we_o), 32'd0);
      check_eq({pfx, "_csr_widx"}, 32'(csr_widx_o), 32'd0);
      check_eq({pfx, "_csr_wdata"}, csr_wdata_o, 32'd0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk_i);
      check_reset_outputs("rst");
      rst_i  = 1'b0;
      mon_en = 1'b1;

      issue(OP_ALLOC, 24'h001000, 24'h000100, 32'h0, 2'd0, 32'hC0001000, 2'd0, 32'hC0001000, 32'hC00010FF);
      issue(OP_ALLOC, 24'h002000, 24'h000010, 32'h0, 2'd0, 32'hC2002000, 2'd2, 32'hC2002000, 32'hC200200F);
      issue(OP_ALLOC, 24'h003000, 24'h000010, 32'h0, 2'd2, 32'h0, 2'd0, 32'h0, 32'h0);
      issue(OP_ALLOC, 24'h003000, 24'h000000, 32'h0, 2'd1, 32'h0, 2'd0, 32'h0, 32'h0);
      issue(OP_FREE,  24'h0, 24'h0, 32'hC0001234, 2'd0, 32'h0, 2'd0, 32'hC0FFFFFF, 32'hC0000000);
      issue(OP_FREE,  24'h0, 24'h0, 32'hC0001234, 2'd3, 32'h0, 2'd0, 32'h0, 32'h0);
      issue(OP_FREE,  24'h0, 24'h0, 32'h12345678, 2'd3, 32'h0, 2'd0, 32'h0, 32'h0);
      issue(OP_ALLOC, 24'h004000, 24'h000000, 32'h0, 2'd1, 32'h0, 2'd0, 32'h0, 32'h0);
      issue(OP_ALLOC, 24'hFFFF00, 24'h000200, 32'h0, 2'd1, 32'h0, 2'd0, 32'h0, 32'h0);
      issue(OP_ALLOC, 24'hFFFF00, 24'h000100, 32'h0, 2'd0, 32'hC0FFFF00, 2'd0, 32'hC0FFFF00, 32'hC0FFFFFF);
      issue(OP_FREE,  24'h0, 24'h0, 32'hC2000000, 2'd0, 32'h0, 2'd2, 32'hC2FFFFFF, 32'hC2000000);
      issue(OP_FREE,  24'h0, 24'h0, 32'hC4000000, 2'd3, 32'h0, 2'd0, 32'h0, 32'h0);
      drain();

      // Response back-pressure: fields hold and a stray request is ignored.
      @(posedge clk_i);
      #1 resp_ready_i = 1'b0;
      issue(OP_ALLOC, 24'h005000, 24'h000020, 32'h0, 2'd0, 32'hC2005000, 2'd2, 32'hC2005000, 32'hC200501F);
      n = 0;
      while (!resp_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check_eq("hold_resp_valid", 32'(resp_valid_o), 32'd1);
         check_eq("hold_resp_ptr", resp_ptr_o, 32'hC2005000);
         check_eq("hold_resp_err", 32'(resp_err_o), 32'd0);
         check_eq("hold_req_ready", 32'(req_ready_o), 32'd0);
         if (i == 1) begin
            req_op_i    = OP_FREE;
            req_ptr_i   = 32'hC0FFFF00;
            req_valid_i = 1'b1;
         end else begin
            req_valid_i = 1'b0;
         end
         @(negedge clk_i);
      end
      @(posedge clk_i);
      #1 resp_ready_i = 1'b1;
      drain();

      issue(OP_FREE, 24'h0, 24'h0, 32'hC2005000, 2'd0, 32'h0, 2'd2, 32'hC2FFFFFF, 32'hC2000000);
      drain();

      // Reset in the middle of an ALLOC that took pair 1.
      mon_en = 1'b0;
      begin
         bit ok;
         wait_ready(ok);
         req_op_i    = OP_ALLOC;
         req_base_i  = 24'h006000;
         req_size_i  = 24'h000040;
         req_valid_i = 1'b1;
         @(posedge clk_i);
         #1 req_valid_i = 1'b0;
         @(posedge clk_i);
         #2 check_eq("pre_reset_csr_we", 32'(csr_we_o), 32'd1);
         rst_i = 1'b1;
         #1 check_reset_outputs("async_rst");
         @(negedge clk_i);
         rst_i = 1'b0;
         mon_en = 1'b1;
      end

      issue(OP_ALLOC, 24'h007000, 24'h000080, 32'h0, 2'd0, 32'hC0007000, 2'd0, 32'hC0007000, 32'hC000707F);
      issue(OP_ALLOC, 24'h008000, 24'h000008, 32'h0, 2'd0, 32'hC2008000, 2'd2, 32'hC2008000, 32'hC2008007);
      drain();
      repeat (3) @(negedge clk_i);
      check_eq("csr_q_leftover", csr_q.size(), 32'd0);
      check_eq("resp_q_leftover", resp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ibex_bcp_region_alloc.md
# ibex_bcp_region_alloc

Hardware allocator that programs the bound-checking region CSRs and issues tagged pointers. The bound checker only decodes region tags (tag[7:6]==2'b11) and reads start/end entries. This block does the encoding side: it picks a free region pair, writes start/end entries through the CSR write port, and returns a tagged pointer. It also invalidates a pair on free. It sits beside the CSR file and is driven by a custom-instruction or MMIO front end through valid/ready handshakes.

## Interface
- XLEN, 32, data width; ALEN = 24 and tag width = 8 are derived exactly as in the checker.
- BCPNumRegions, 4, number of region CSR entries; even and ≥4; NumPairs = BCPNumRegions/2.
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_op_i  in  1  bcp_alloc_op_e: 0 = ALLOC, 1 = FREE
- req_base_i  in  24  ALLOC base address
- req_size_i  in  24  ALLOC size in bytes
- req_ptr_i  in  32  FREE tagged pointer
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_ptr_o  out  32  ALLOC result {tag, base}; 0 on error or FREE
- resp_err_o  out  2  bcp_alloc_err_e: OK=0, BADSIZE=1, NOFREE=2, BADFREE=3
- csr_we_o  out  1  region CSR write strobe
- csr_widx_o  out  $clog2(BCPNumRegions)  entry index
- csr_wdata_o  out  32  entry value {tag, addr}

## Operation
- Pair k uses entries 2k (start) and 2k+1 (end). Its tag is 8'hC0 | (k<<1). Bit0 is always 0, so the tag is never 8'hFF and the checker's index decode recovers k.
- Free bitmap: NumPairs bits, all 1 at reset. Lowest set bit is the selected pair (combinational priority encode).
- ALLOC checks, in priority order:
  - size==0, or base+size-1 carries out of 24 bits → BADSIZE.
  - Bitmap all zero → NOFREE.
  - Otherwise write start = {tag, base}, then end = {tag, base+size-1}, clear bit k, respond with {tag, base}.
- FREE check: ptr[31:30]!=2'b11, or ptr[23:0]-independent index k ≥ NumPairs, or bit k already free → BADFREE.
  - Otherwise write start = {tag, 24'hFFFFFF}, then end = {tag, 24'h000000}, set bit k. The start>end encoding makes the checker fault any stale use.
- Errors perform no CSR write and leave the bitmap unchanged.
- State machine: IDLE → (accept, no error) WR_START → WR_END → RESP → (resp_ready_i) IDLE. On an error, IDLE → RESP directly.
- Request fields are registered on accept. Inputs are ignored outside IDLE.

## Timing
- req_ready_o = (state==IDLE). Only one operation is outstanding at a time.
- Request accepted at edge T:
  - csr_we_o is high during cycle T+1 (start entry) and T+2 (end entry).
  - Bitmap updates at the end of T+2.
  - resp_valid_o rises at T+3.
- Error request accepted at T: resp_valid_o at T+1, csr_we_o never asserted.
- resp_valid_o and all resp fields stay stable until resp_ready_i is high. The earliest next request is accepted the cycle after the response handshake.
- csr_we_o is a single-cycle strobe. csr_widx_o and csr_wdata_o are valid only while it is high and 0 otherwise.
- Reset values: req_ready_o=1, resp_valid_o=0, resp_ptr_o=0, resp_err_o=0, csr_we_o=0, csr_widx_o=0, csr_wdata_o=0, state=IDLE, bitmap all ones.
- Reset mid-operation aborts immediately. A half-written pair may remain in the CSRs; boot software must reprogram all entries after reset.

## Structure
- ibex_pkg gains:
  - bcp_alloc_op_e
  - bcp_alloc_err_e
  - state enum bcp_alloc_state_e
  - localparams BCP_TAG_REGION = 2'b11 and BCP_TAG_INV_START = 24'hFFFFFF
- One sub-module: ibex_bcp_free_finder, a parameterised lowest-set-bit priority encoder with an any-set flag.

## Test plan
- BCPNumRegions=4; ALLOC base 0x001000, size 0x100 → entry0 = 0xC0001000 at T+1, entry1 = 0xC00010FF at T+2, resp_ptr 0xC0001000, OK at T+3.
- Second ALLOC base 0x002000, size 0x10 → entries 2/3 = 0xC2002000 / 0xC200200F, resp 0xC2002000. A third ALLOC → NOFREE at T+1, no csr_we_o.
- FREE 0xC0001234 → entry0 = 0xC0FFFFFF, entry1 = 0xC0000000, OK. A repeat FREE 0xC0001234 → BADFREE; FREE 0x12345678 → BADFREE.
- ALLOC size 0 → BADSIZE. ALLOC base 0xFFFF00, size 0x200 → BADSIZE. ALLOC base 0xFFFF00, size 0x100 → OK, end 0xC0FFFFFF.
- Hold resp_ready_i low 5 cycles → resp fields stable, req_ready_o stays low, a pulsed req_valid_i is ignored.
- Assert rst_i during WR_END → all outputs return to reset values asynchronously, the bitmap is all ones, and the next ALLOC picks pair 0.
